cache_ctrl_4way: RTL and testbench
==================================

# cache_ctrl_4way

Request sequencer for the 4-way set-associative byte cache. It holds the tag/valid state and the per-set replacement state. It compares tags and steers the per-way write enables and set index of the external data array (one 8-bit register per way per set). It also runs a write-through request/acknowledge handshake to backing memory. It sits between the CPU-side request port and the data-array/memory datapath.

## Interface
Parameters:
- ADDR_W, 8: byte address width; addr[IDX_W-1:0] = set index, remaining upper bits = tag.
- SETS, 8: sets per way (power of two); IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- cpu_req  in  1  request valid; accepted only when cpu_ready=1.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  8  write data.
- cpu_ready  out  1  controller idle and able to accept a request.
- cpu_valid  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data; meaningful only while cpu_valid=1 for a read.
- arr_set  out  IDX_W  set index to the data array.
- arr_we  out  4  one-hot per-way byte write enable.
- arr_wdata  out  8  data to the data array.
- arr_rdata  in  32  current bytes of the four ways at arr_set; way w is on bits [8w+7:8w].
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write (write-through).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  8  memory write data.
- mem_ack  in  1  one-cycle completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  8  memory read data.

## Operation
- States:
  - IDLE: cpu_ready=1. cpu_req captures addr, we and wdata, then moves to LOOKUP.
  - LOOKUP: compares the captured tag against the 4 valid tags of the set. Exits:
    - read hit → RESP
    - read miss → MEM_RD
    - any write → MEM_WR
  - MEM_RD: mem_req=1, mem_we=0. On mem_ack, captures mem_rdata and goes to FILL.
  - FILL: arr_we = one-hot victim, arr_wdata = captured data. Writes tag, sets valid, updates replacement state. Goes to RESP.
  - MEM_WR: mem_req=1, mem_we=1. On a write hit, arr_we for the hit way is asserted in the first MEM_WR cycle only, and the hit way's replacement state is updated. On mem_ack goes to RESP. No allocate on a write miss.
  - RESP: cpu_valid=1 for one cycle, then IDLE.
- cpu_rdata on a read hit comes from arr_rdata of the hit way; on a miss it is the captured mem_rdata.
- Victim choice: the lowest-index invalid way; if all four ways are valid, the replacement policy decides (see Configuration).
- mem_ack outside MEM_RD/MEM_WR is ignored. cpu_req while cpu_ready=0 is ignored and not queued.
- More than one matching valid way cannot occur by construction. If it does, the lowest index wins.
- Reset (reset=0 at a clk edge):
  - state = IDLE, all valid bits = 0, replacement state = 0
  - cpu_valid, mem_req, mem_we and arr_we = 0
  - cpu_rdata, mem_addr and mem_wdata = 0
  - Applies mid-operation: an outstanding memory request is dropped at that edge and a later mem_ack is ignored.
  - cpu_ready=0 while reset=0 and 1 in the first cycle after release.

## Timing
- Read hit: accepted at edge 0, LOOKUP in cycle 1, cpu_valid in cycle 2. Latency 2.
- Read miss: mem_req rises in cycle 2. If mem_ack is in cycle k, FILL is in k+1 and cpu_valid in k+2.
- Write: mem_req rises in cycle 2. On a hit, arr_we is also asserted in cycle 2. If mem_ack is in cycle k, cpu_valid is in k+1.
- mem_ack in the first mem_req cycle is legal. Minimum read-miss latency is 4 cycles.
- All outputs are registered except cpu_ready and cpu_rdata, which are decoded from state.

## Configuration
- CACHE_PLRU_EN:
  - Defined: 3-bit tree pseudo-LRU per set.
    - Victim selection: b0=0 selects the {0,1} half, b1 picks within it (0→way0). b0=1 selects the {2,3} half, b2 picks within it (0→way2).
    - Access updates: way0 sets b0=1,b1=1; way1 sets b0=1,b1=0; way2 sets b0=0,b2=1; way3 sets b0=0,b2=0.
  - Undefined: one global 2-bit round-robin counter, used as the victim and incremented on every fill that finds all four ways valid. No per-set state; hits update nothing.

## Structure
- Shared package cache_pkg:
  - state enum
  - WAYS=4, PLRU_W=3
  - way index typedef
- Sub-module plru_tree4: combinational victim function and next-bit update from (bits, accessed way). Instantiated only under CACHE_PLRU_EN.

## Test plan
- Reset, then read 0x2A with mem_ack 3 cycles after mem_req and mem_rdata=0x5C → fill way0 of set 2, cpu_valid with cpu_rdata=0x5C. Repeating the read 0x2A → cpu_valid 2 cycles after accept, rdata 0x5C, no mem_req.
- Read misses 0x2A, 0x32, 0x3A, 0x42 → fills ways 0,1,2,3 of set 2. Then read 0x4A → victim way0 in both configurations.
- Same sequence, plus a read hit on 0x2A before 0x4A → victim way2 with CACHE_PLRU_EN, way0 without.
- Write 0x2A with 0x11 after fill → arr_we=0001 in cycle 2, mem_req/mem_we with mem_wdata=0x11. Write miss 0x7F → no arr_we, mem write only.
- Assert reset while in MEM_RD, then pulse mem_ack → no fill, no cpu_valid, next read of the same address misses.
- cpu_req held during a miss → only one request accepted; cpu_ready=0 until RESP completes.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the 4-way cache request sequencer
package cache_pkg;

    localparam int WAYS   = 4;
    localparam int PLRU_W = 3;

    typedef logic [1:0] way_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_RD,
        ST_FILL,
        ST_MEM_WR,
        ST_RESP
    } state_t;

    function automatic logic [WAYS-1:0] way_onehot(input way_t w);
        return 4'b0001 << w;
    endfunction

endpackage

// File: rtl/plru_tree4.sv
// rtl/plru_tree4.sv - 3-bit tree pseudo-LRU: victim decode and post-access bit update
module plru_tree4
    import cache_pkg::*;
(
    input  logic [PLRU_W-1:0] i_bits,
    input  way_t              i_way,
    output way_t              o_victim,
    output logic [PLRU_W-1:0] o_bits_nxt
);

    // b0 picks the half, b1/b2 pick within the {0,1}/{2,3} half
    assign o_victim = i_bits[0] ? {1'b1, i_bits[2]} : {1'b0, i_bits[1]};

    always_comb begin
        o_bits_nxt = i_bits;
        if (!i_way[1]) begin
            o_bits_nxt[0] = 1'b1;
            o_bits_nxt[1] = ~i_way[0];
        end else begin
            o_bits_nxt[0] = 1'b0;
            o_bits_nxt[2] = ~i_way[0];
        end
    end

endmodule

// File: rtl/cache_ctrl_4way.sv
// rtl/cache_ctrl_4way.sv - 4-way byte cache sequencer with write-through memory handshake
// CACHE_PLRU_EN selects per-set tree pseudo-LRU; otherwise a global round-robin victim counter.
module cache_ctrl_4way
    import cache_pkg::*;
#(
    parameter  int ADDR_W = 8,
    parameter  int SETS   = 8,
    localparam int IDX_W  = $clog2(SETS),
    localparam int TAG_W  = ADDR_W - IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_valid,
    output logic [7:0]        cpu_rdata,
    output logic [IDX_W-1:0]  arr_set,
    output logic [WAYS-1:0]   arr_we,
    output logic [7:0]        arr_wdata,
    input  logic [31:0]       arr_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [7:0]          r_wdata;
    logic [7:0]          r_mdata;
    logic                r_hit;
    way_t                r_hit_way;
    way_t                r_victim;
    logic [WAYS-1:0]     r_valid [SETS];
    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    way_t                w_hit_way;
    logic                w_free;
    way_t                w_free_way;
    way_t                w_policy_way;
    way_t                w_victim;
    logic                w_cpu_valid_nxt;
    logic                w_mem_req_nxt;
    logic                w_mem_we_nxt;
    logic [WAYS-1:0]     w_arr_we_nxt;

    assign w_idx = r_addr[IDX_W-1:0];
    assign w_tag = r_addr[ADDR_W-1:IDX_W];

    // Scan downward so the lowest matching / lowest invalid way wins
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_free     = 1'b0;
        w_free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = way_t'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_free     = 1'b1;
                w_free_way = way_t'(w);
            end
        end
    end

`ifdef CACHE_PLRU_EN
    logic [PLRU_W-1:0] r_plru [SETS];
    logic [PLRU_W-1:0] w_plru_nxt;
    way_t              w_upd_way;

    assign w_upd_way = (r_state == ST_FILL) ? r_victim : w_hit_way;

    plru_tree4 u_plru (
        .i_bits     (r_plru[w_idx]),
        .i_way      (w_upd_way),
        .o_victim   (w_policy_way),
        .o_bits_nxt (w_plru_nxt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
        end else if ((r_state == ST_LOOKUP && w_hit) || r_state == ST_FILL) begin
            r_plru[w_idx] <= w_plru_nxt;
        end
    end
`else
    logic [1:0] r_rr;

    assign w_policy_way = r_rr;

    always_ff @(posedge clk) begin
        if (!reset)
            r_rr <= '0;
        else if (r_state == ST_FILL && !w_free)
            r_rr <= r_rr + 2'd1;
    end
`endif

    assign w_victim = w_free ? w_free_way : w_policy_way;

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (cpu_req) w_state_nxt = ST_LOOKUP;
            ST_LOOKUP: w_state_nxt = r_we ? ST_MEM_WR : (w_hit ? ST_RESP : ST_MEM_RD);
            ST_MEM_RD: if (mem_ack) w_state_nxt = ST_FILL;
            ST_FILL:   w_state_nxt = ST_RESP;
            ST_MEM_WR: if (mem_ack) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_cpu_valid_nxt = (w_state_nxt == ST_RESP);
        w_mem_req_nxt   = (w_state_nxt == ST_MEM_RD) || (w_state_nxt == ST_MEM_WR);
        w_mem_we_nxt    = (w_state_nxt == ST_MEM_WR);
        w_arr_we_nxt    = '0;
        if (r_state == ST_LOOKUP && r_we && w_hit)
            w_arr_we_nxt = way_onehot(w_hit_way);
        if (r_state == ST_MEM_RD && mem_ack)
            w_arr_we_nxt = way_onehot(w_victim);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_valid <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            arr_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            arr_set   <= '0;
            arr_wdata <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_mdata   <= '0;
            r_hit     <= 1'b0;
            r_hit_way <= '0;
            r_victim  <= '0;
        end else begin
            cpu_valid <= w_cpu_valid_nxt;
            mem_req   <= w_mem_req_nxt;
            mem_we    <= w_mem_we_nxt;
            arr_we    <= w_arr_we_nxt;
            case (r_state)
                ST_IDLE: if (cpu_req) begin
                    r_addr  <= cpu_addr;
                    r_we    <= cpu_we;
                    r_wdata <= cpu_wdata;
                    arr_set <= cpu_addr[IDX_W-1:0];
                end
                ST_LOOKUP: begin
                    r_hit     <= w_hit;
                    r_hit_way <= w_hit_way;
                    mem_addr  <= r_addr;
                    mem_wdata <= r_wdata;
                    arr_wdata <= r_wdata;
                end
                ST_MEM_RD: if (mem_ack) begin
                    r_mdata   <= mem_rdata;
                    arr_wdata <= mem_rdata;
                    r_victim  <= w_victim;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else if (r_state == ST_FILL) begin
            r_valid[w_idx][r_victim] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_FILL)
            r_tag[w_idx][r_victim] <= w_tag;
    end

    assign cpu_ready = reset && (r_state == ST_IDLE);
    assign cpu_rdata = (r_state == ST_RESP && !r_we)
                     ? (r_hit ? arr_rdata[{r_hit_way, 3'b000} +: 8] : r_mdata)
                     : 8'h00;

endmodule

// File: tb/tb_cache_ctrl_4way.sv
// tb/tb_cache_ctrl_4way.sv - directed self-checking bench for cache_ctrl_4way
module tb_cache_ctrl_4way;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_addr = 8'h00;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_ready;
    logic        cpu_valid;
    logic [7:0]  cpu_rdata;
    logic [2:0]  arr_set;
    logic [3:0]  arr_we;
    logic [7:0]  arr_wdata;
    logic [31:0] arr_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    int          lat, mreq_cyc, awe_cyc, awe_cnt, rdy_cnt, cnt_v, cnt_w;
    logic [7:0]  rd, maddr, mwd;
    logic        mwe;
    logic [3:0]  awe_val;
    logic [3:0]  exp_victim;

    logic [7:0] darr [8][4];

    always #5 clk = ~clk;

    always @(posedge clk)
        for (int w = 0; w < 4; w++)
            if (arr_we[w]) darr[arr_set][w] <= arr_wdata;

    assign arr_rdata = {darr[arr_set][3], darr[arr_set][2], darr[arr_set][1], darr[arr_set][0]};

    cache_ctrl_4way #(.ADDR_W(8), .SETS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_valid (cpu_valid),
        .cpu_rdata (cpu_rdata),
        .arr_set   (arr_set),
        .arr_we    (arr_we),
        .arr_wdata (arr_wdata),
        .arr_rdata (arr_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One CPU transaction; cycle c is the cycle after accept edge c-1
    task automatic run_req(input logic [7:0] addr, input logic we, input logic [7:0] wd,
                           input int ack_dly, input logic [7:0] mrd, input logic hold);
        cpu_addr = addr; cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1;
        lat = 0; rd = 8'h00; mreq_cyc = 0; mwe = 1'b0; maddr = 8'h00; mwd = 8'h00;
        awe_cyc = 0; awe_val = 4'h0; awe_cnt = 0; rdy_cnt = 0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!hold) cpu_req = 1'b0;
            if (cpu_ready) rdy_cnt++;
            if (mem_req && mreq_cyc == 0) begin
                mreq_cyc = c; mwe = mem_we; maddr = mem_addr; mwd = mem_wdata;
            end
            if (arr_we != 4'h0) begin
                awe_cnt++;
                if (awe_cyc == 0) begin awe_cyc = c; awe_val = arr_we; end
            end
            if (mem_req && mreq_cyc != 0 && c == mreq_cyc + ack_dly) begin
                mem_ack = 1'b1; mem_rdata = mrd;
            end
            if (cpu_valid) begin lat = c; rd = cpu_rdata; cpu_req = 1'b0; end
        end
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready",     cpu_ready, 0);
        chk("rst_valid",     cpu_valid, 0);
        chk("rst_mem_req",   mem_req,   0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_arr_we",    arr_we,    0);
        chk("rst_rdata",     cpu_rdata, 0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cpu_ready, 1);

        // read miss 0x2A, ack 3 cycles after mem_req
        run_req(8'h2A, 1'b0, 8'h00, 3, 8'h5C, 1'b0);
        chk("miss_mreq_cyc", mreq_cyc, 2);
        chk("miss_mem_we",   mwe,      0);
        chk("miss_mem_addr", maddr,    8'h2A);
        chk("miss_fill_cyc", awe_cyc,  6);
        chk("miss_fill_way", awe_val,  4'b0001);
        chk("miss_lat",      lat,      7);
        chk("miss_rdata",    rd,       8'h5C);
        chk("miss_ready_lo", rdy_cnt,  0);

        run_req(8'h2A, 1'b0, 8'h00, 0, 8'hFF, 1'b0);
        chk("hit_lat",     lat,      2);
        chk("hit_rdata",   rd,       8'h5C);
        chk("hit_no_mreq", mreq_cyc, 0);
        chk("hit_no_awe",  awe_cnt,  0);

        // fill remaining ways of set 2, minimum miss latency
        run_req(8'h32, 1'b0, 8'h00, 0, 8'h63, 1'b0);
        chk("fill1_way", awe_val, 4'b0010);
        chk("fill1_lat", lat,     4);
        run_req(8'h3A, 1'b0, 8'h00, 0, 8'h74, 1'b0);
        chk("fill2_way", awe_val, 4'b0100);
        run_req(8'h42, 1'b0, 8'h00, 0, 8'h85, 1'b0);
        chk("fill3_way", awe_val, 4'b1000);
        run_req(8'h4A, 1'b0, 8'h00, 0, 8'h96, 1'b0);
        chk("evict_way",   awe_val, 4'b0001);
        chk("evict_rdata", rd,      8'h96);

        // same fills from reset, then touch 0x2A before the eviction
        do_reset();
        run_req(8'h2A, 1'b0, 8'h00, 0, 8'h5C, 1'b0);
        run_req(8'h32, 1'b0, 8'h00, 0, 8'h63, 1'b0);
        run_req(8'h3A, 1'b0, 8'h00, 0, 8'h74, 1'b0);
        run_req(8'h42, 1'b0, 8'h00, 0, 8'h85, 1'b0);
        chk("p_fill3_way", awe_val, 4'b1000);
        run_req(8'h2A, 1'b0, 8'h00, 0, 8'hFF, 1'b0);
        chk("p_hit_lat",   lat, 2);
        chk("p_hit_rdata", rd,  8'h5C);
        run_req(8'h4A, 1'b0, 8'h00, 0, 8'h96, 1'b0);
`ifdef CACHE_PLRU_EN
        exp_victim = 4'b0100;
`else
        exp_victim = 4'b0001;
`endif
        chk("policy_victim", awe_val, exp_victim);

        // write hit / write miss
        do_reset();
        run_req(8'h2A, 1'b0, 8'h00, 0, 8'h5C, 1'b0);
        run_req(8'h2A, 1'b1, 8'h11, 1, 8'h00, 1'b0);
        chk("wh_awe_cyc",  awe_cyc,  2);
        chk("wh_awe_val",  awe_val,  4'b0001);
        chk("wh_awe_cnt",  awe_cnt,  1);
        chk("wh_mreq_cyc", mreq_cyc, 2);
        chk("wh_mem_we",   mwe,      1);
        chk("wh_wdata",    mwd,      8'h11);
        chk("wh_addr",     maddr,    8'h2A);
        chk("wh_lat",      lat,      4);
        run_req(8'h2A, 1'b0, 8'h00, 0, 8'hFF, 1'b0);
        chk("wh_readback", rd,  8'h11);
        chk("wh_rb_lat",   lat, 2);
        run_req(8'h7F, 1'b1, 8'h22, 0, 8'h00, 1'b0);
        chk("wm_awe_cnt", awe_cnt, 0);
        chk("wm_mem_we",  mwe,     1);
        chk("wm_addr",    maddr,   8'h7F);
        chk("wm_wdata",   mwd,     8'h22);
        chk("wm_lat",     lat,     3);
        run_req(8'h7F, 1'b0, 8'h00, 0, 8'h33, 1'b0);
        chk("wm_no_alloc", mreq_cyc, 2);
        chk("wm_rd_rdata", rd,       8'h33);

        // cpu_req held across a miss
        run_req(8'h52, 1'b0, 8'h00, 2, 8'h44, 1'b1);
        chk("hold_ready_lo", rdy_cnt, 0);
        chk("hold_lat",      lat,     6);
        chk("hold_fill_way", awe_val, 4'b0010);
        chk("hold_ready_hi", cpu_ready, 1);
        cnt_v = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cpu_valid || mem_req) cnt_v++;
        end
        chk("hold_single", cnt_v, 0);

        // reset while in MEM_RD, then a stale ack
        do_reset();
        cpu_addr = 8'h2A; cpu_we = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("mr_mreq_up", mem_req, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_mreq_drop", mem_req,   0);
        chk("mr_ready_lo",  cpu_ready, 0);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hEE;
        @(negedge clk);
        mem_ack = 1'b0;
        cnt_v = 0; cnt_w = 0;
        for (int c = 0; c < 8; c++) begin
            if (cpu_valid) cnt_v++;
            if (arr_we != 4'h0 || mem_req) cnt_w++;
            @(negedge clk);
        end
        chk("mr_no_valid", cnt_v, 0);
        chk("mr_no_fill",  cnt_w, 0);
        run_req(8'h2A, 1'b0, 8'h00, 0, 8'h5D, 1'b0);
        chk("mr_remiss",  mreq_cyc, 2);
        chk("mr_lat",     lat,      4);
        chk("mr_rdata",   rd,       8'h5D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
